// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication, load extraction/extension, legality check
module lsu_align
    import lsu_pkg::*;
(
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] write_data,
    input  logic [2:0]        rsp_funct3,
    input  logic [1:0]        rsp_addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              illegal
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        be    = 4'b0000;
        wdata = write_data;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{write_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{write_data[15:0]}};
            end
            F3_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (mem_read && mem_write)
            illegal = 1'b1;
        case (funct3)
            F3_B, F3_BU: ;
            F3_H, F3_HU: if (addr_lo[0]) illegal = 1'b1;
            F3_W:        if (addr_lo != 2'b00) illegal = 1'b1;
            default:     illegal = 1'b1;
        endcase
        // unsigned sizes only exist for loads
        if (mem_write && (funct3 == F3_BU || funct3 == F3_HU))
            illegal = 1'b1;
    end

    always_comb begin
        case (rsp_addr_lo)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = rsp_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (rsp_funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'd0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'd0, lane_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - stalling load/store unit between datapath and a slow data memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Stall,
    output logic              access_fault,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_addr_lo;
    logic              access, illegal, abort, capture, launch;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c, load_c;

    assign access = MemRead | MemWrite;
    assign launch = (state == IDLE) && access && !illegal;

    lsu_align u_align (
        .mem_read    (MemRead),
        .mem_write   (MemWrite),
        .funct3      (funct3),
        .addr_lo     (ALUResult[1:0]),
        .write_data  (WriteData),
        .rsp_funct3  (lat_funct3),
        .rsp_addr_lo (lat_addr_lo),
        .rdata       (mem_rdata),
        .be          (be_c),
        .wdata       (wdata_c),
        .load_data   (load_c),
        .illegal     (illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        mem_req    = 1'b0;
        abort      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    Stall      = 1'b1;
                    next_state = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt)
                    next_state = mem_we ? DONE : RSP;
                else if (cnt == CNT_LAST) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
            end
            RSP: begin
                Stall = 1'b1;
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end else if (cnt == CNT_LAST) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // counter restarts whenever a wait state is entered fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if ((next_state == REQ && state != REQ) || (next_state == RSP && state != RSP))
            cnt <= '0;
        else if (state == REQ || state == RSP)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'b0000;
            mem_wdata    <= '0;
            lat_funct3   <= 3'b000;
            lat_addr_lo  <= 2'b00;
            Read_Data    <= '0;
            access_fault <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            access_fault <= (state == IDLE) && access && illegal;
            bus_error    <= abort;
            if (launch) begin
                mem_we      <= MemWrite;
                mem_addr    <= {ALUResult[ADDR_W-1:2], 2'b00};
                mem_be      <= be_c;
                mem_wdata   <= wdata_c;
                lat_funct3  <= funct3;
                lat_addr_lo <= ALUResult[1:0];
            end
            if (abort)
                Read_Data <= '0;
            else if (capture)
                Read_Data <= load_c;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] Read_Data;
    logic        Stall, access_fault, bus_error;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .funct3       (funct3),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .Read_Data    (Read_Data),
        .Stall        (Stall),
        .access_fault (access_fault),
        .bus_error    (bus_error),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rd;
        logic        af;
        logic        be;
        int          stall;
        int          req;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];

    int checks = 0;
    int passed = 0;

    // responder controls
    bit          withhold = 0;
    bit          hold_rsp = 0;
    bit          force_rv = 0;
    logic [31:0] rsp_word = '0;
    logic [31:0] force_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    initial begin : responder
        bit pend_load;
        pend_load  = 0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = (pend_load && !hold_rsp) || force_rv;
            mem_rdata  = force_rv ? force_word : rsp_word;
            mem_gnt    = mem_req && !withhold && !reset;
            pend_load  = mem_gnt && !mem_we;
        end
    end

    initial begin : monitor
        int   stall_cnt, req_cnt;
        logic prev_stall;
        bus_t  b;
        done_t d;
        stall_cnt  = 0;
        req_cnt    = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stall_cnt  = 0;
                req_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (Stall)   stall_cnt++;
                if (mem_req) req_cnt++;
                if (mem_req && mem_gnt) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        $display("FAIL bus_unexpected: handshake addr 0x%08h with nothing expected", mem_addr);
                    end else begin
                        b = bus_q.pop_front();
                        check("mem_we", {31'd0, mem_we}, {31'd0, b.we});
                        check("mem_addr", mem_addr, b.addr);
                        if (b.we) begin
                            check("mem_be", {28'd0, mem_be}, {28'd0, b.be});
                            check("mem_wdata", mem_wdata, b.wdata);
                        end
                    end
                end
                if (prev_stall && !Stall) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        $display("FAIL done_unexpected: completion with nothing expected");
                    end else begin
                        d = done_q.pop_front();
                        check("Read_Data", Read_Data, d.rd);
                        check("access_fault", {31'd0, access_fault}, {31'd0, d.af});
                        check("bus_error", {31'd0, bus_error}, {31'd0, d.be});
                        check("stall_cycles", stall_cnt, d.stall);
                        check("req_cycles", req_cnt, d.req);
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end else if (access_fault || bus_error) begin
                    checks++;
                    $display("FAIL stray_pulse: access_fault=%0b bus_error=%0b outside completion", access_fault, bus_error);
                end
                prev_stall = Stall;
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                          input bit wh, input bit hold,
                          input logic [31:0] exp_rd, input logic exp_af, input logic exp_be,
                          input int exp_stall, input int exp_req,
                          input logic [3:0] exp_mbe, input logic [31:0] exp_mwdata);
        bus_t  b;
        done_t d;
        bit    got;
        if (exp_req > 0 && !wh) begin
            b.we    = wr;
            b.addr  = {addr[31:2], 2'b00};
            b.be    = exp_mbe;
            b.wdata = exp_mwdata;
            bus_q.push_back(b);
        end
        d.rd    = exp_rd;
        d.af    = exp_af;
        d.be    = exp_be;
        d.stall = exp_stall;
        d.req   = exp_req;
        done_q.push_back(d);
        @(negedge clk);
        withhold  = wh;
        hold_rsp  = hold;
        rsp_word  = rword;
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (!Stall) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL completion_timeout: Stall still high after 40 cycles at addr 0x%08h", addr);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'b000;
        ALUResult = '0;
        WriteData = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_Read_Data", Read_Data, 32'h0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_flags", {29'd0, mem_we, access_fault, bus_error}, 32'd0);
        check("rst_Stall", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //      rd wr f3      addr          wdata         rword         wh hold exp_rd        af be st rq mbe      mwdata
        access(0, 1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0000_0000, 0, 0, 2, 1, 4'b1111, 32'hDEAD_BEEF);
        access(1, 0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_0000, 0, 0, 32'hFFFF_FF80, 0, 0, 3, 1, 4'b0000, 32'h0);
        access(1, 0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_0000, 0, 0, 32'h0000_0080, 0, 0, 3, 1, 4'b0000, 32'h0);
        access(0, 1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'h0,        0, 0, 32'h0000_0080, 0, 0, 2, 1, 4'b1100, 32'hABCD_ABCD);
        access(1, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 32'h0000_0080, 1, 0, 1, 0, 4'b0000, 32'h0);
        access(1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_1234, 0, 0, 32'hFFFF_8001, 0, 0, 3, 1, 4'b0000, 32'h0);
        access(1, 0, 3'b101, 32'h0000_0000, 32'h0,        32'hF00F_8765, 0, 0, 32'h0000_8765, 0, 0, 3, 1, 4'b0000, 32'h0);
        access(1, 0, 3'b010, 32'h0000_0008, 32'h0,        32'hCAFE_BABE, 0, 0, 32'hCAFE_BABE, 0, 0, 3, 1, 4'b0000, 32'h0);
        access(0, 1, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'h0,        0, 0, 32'hCAFE_BABE, 0, 0, 2, 1, 4'b0010, 32'h7878_7878);
        // illegal commands: store BU, read+write together, reserved funct3, odd halfword
        access(0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'hCAFE_BABE, 1, 0, 1, 0, 4'b0000, 32'h0);
        access(1, 1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'hCAFE_BABE, 1, 0, 1, 0, 4'b0000, 32'h0);
        access(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'hCAFE_BABE, 1, 0, 1, 0, 4'b0000, 32'h0);
        access(0, 1, 3'b001, 32'h0000_0013, 32'h0,        32'h0,        0, 0, 32'hCAFE_BABE, 1, 0, 1, 0, 4'b0000, 32'h0);
        // grant withheld: 16 request cycles, then abort
        access(1, 0, 3'b010, 32'h0000_0040, 32'h0,        32'h0,        1, 0, 32'h0000_0000, 0, 1, 17, 16, 4'b0000, 32'h0);
        access(1, 0, 3'b010, 32'h0000_000C, 32'h0,        32'h1122_3344, 0, 0, 32'h1122_3344, 0, 0, 3, 1, 4'b0000, 32'h0);
        // response withheld: 16 response cycles, then abort
        access(1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 1, 18, 1, 4'b0000, 32'h0);

        // reset while waiting in RSP, then a late response
        begin
            bus_t b;
            b.we = 1'b0; b.addr = 32'h0000_0100; b.be = 4'b0000; b.wdata = 32'h0;
            bus_q.push_back(b);
        end
        @(negedge clk);
        withhold  = 0;
        hold_rsp  = 1;
        MemRead   = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h0000_0100;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rsp_wait_Stall", {31'd0, Stall}, 32'd1);
        reset   = 1'b1;
        MemRead = 1'b0;
        #1;
        check("async_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_Stall", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #3;
        force_word = 32'h1234_5678;
        force_rv   = 1;
        @(negedge clk);
        #3;
        force_rv = 0;
        @(negedge clk);
        #1;
        check("late_rsp_Read_Data", Read_Data, 32'h0);
        check("late_rsp_Stall", {31'd0, Stall}, 32'd0);
        check("late_rsp_mem_req", {31'd0, mem_req}, 32'd0);
        check("late_rsp_flags", {30'd0, access_fault, bus_error}, 32'd0);
        repeat (2) @(negedge clk);
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
